// File: rtl/wb_timer_if.sv
// Wishbone register-port bundle used by wb_timer.
// The responder drives only dat_o and ack.
interface if_wb #(
  parameter int ADR_W = 16
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [15:0]      dat_i;
  logic [15:0]      dat_o;
  logic             ack;

  modport slave  (input cyc, stb, we, adr, dat_i, output dat_o, ack);
  modport master (output cyc, stb, we, adr, dat_i, input dat_o, ack);
endinterface

// File: rtl/wb_timer.sv
// Prescaled 16-bit down-counter timer with a Wishbone register port and a level interrupt.
// Registers: 0 CTRL{IE,RELOAD,EN}, 1 STATUS{EXP}, 2 PRESCALE, 3 LOAD, 4 COUNT.
module wb_timer #(
  parameter int ADR_W = 16
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  if_wb.slave  wbs,
  output logic irq_o
);

  logic             en, reload, ie, exp;
  logic [15:0]      prescale, load, count, pcnt;
  logic             en_n, reload_n, ie_n, exp_n;
  logic [15:0]      prescale_n, load_n, count_n, pcnt_n;
  logic [ADR_W-1:0] adr;
  logic [2:0]       sel;
  logic             access, wr;
  logic             wr_ctrl, wr_status, wr_prescale, wr_load, wr_count;
  logic             tick, tick_eff;
  logic [15:0]      rdata;
  logic             unused_adr;

  assign adr        = wbs.adr;
  assign sel        = adr[2:0];
  assign unused_adr = ^adr[ADR_W-1:3];

  assign access      = wbs.cyc & wbs.stb;
  assign wr          = access & wbs.we;
  assign wr_ctrl     = wr & (sel == 3'd0);
  assign wr_status   = wr & (sel == 3'd1);
  assign wr_prescale = wr & (sel == 3'd2);
  assign wr_load     = wr & (sel == 3'd3);
  assign wr_count    = wr & (sel == 3'd4);

  always_comb begin
    case (sel)
      3'd0:    rdata = {13'd0, ie, reload, en};
      3'd1:    rdata = {15'd0, exp};
      3'd2:    rdata = prescale;
      3'd3:    rdata = load;
      3'd4:    rdata = count;
      default: rdata = 16'h0000;
    endcase
  end

  // A CTRL write that drops EN swallows the tick landing in the same cycle.
  assign tick     = en & (pcnt == prescale);
  assign tick_eff = tick & ~(wr_ctrl & ~wbs.dat_i[0]);

  always_comb begin
    en_n       = en;
    reload_n   = reload;
    ie_n       = ie;
    exp_n      = exp;
    prescale_n = prescale;
    load_n     = load;
    count_n    = count;
    pcnt_n     = tick ? 16'd0 : pcnt + 16'd1;

    if (wr_ctrl) begin
      en_n     = wbs.dat_i[0];
      reload_n = wbs.dat_i[1];
      ie_n     = wbs.dat_i[2];
    end
    if (wr_status && wbs.dat_i[0]) exp_n = 1'b0;
    if (wr_prescale) prescale_n = wbs.dat_i;
    if (wr_load) load_n = wbs.dat_i;

    // A direct COUNT write beats the tick; expiry beats a STATUS clear.
    if (wr_count) begin
      count_n = wbs.dat_i;
    end else if (tick_eff) begin
      if (count != 16'd0) begin
        count_n = count - 16'd1;
      end else begin
        exp_n = 1'b1;
        if (reload) count_n = load;
        else        en_n    = 1'b0;
      end
    end

    if (wr_prescale || (wr_ctrl && wbs.dat_i[0] && !en) || !en_n) pcnt_n = 16'd0;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      en        <= 1'b0;
      reload    <= 1'b0;
      ie        <= 1'b0;
      exp       <= 1'b0;
      prescale  <= 16'd0;
      load      <= 16'd0;
      count     <= 16'd0;
      pcnt      <= 16'd0;
      wbs.ack   <= 1'b0;
      wbs.dat_o <= 16'd0;
      irq_o     <= 1'b0;
    end else begin
      en        <= en_n;
      reload    <= reload_n;
      ie        <= ie_n;
      exp       <= exp_n;
      prescale  <= prescale_n;
      load      <= load_n;
      count     <= count_n;
      pcnt      <= pcnt_n;
      wbs.ack   <= access;
      if (access) wbs.dat_o <= rdata;
      irq_o     <= ie & exp;
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: every bus access pushes its expected response,
// which is popped and compared in the cycle the acknowledge is due.
module tb_wb_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;

  if_wb #(.ADR_W(16)) bus ();

  wb_timer #(.ADR_W(16)) dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst),
    .wbs      (bus),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_q[$];
  string       tag_q[$];

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step();
    logic [16:0] e;
    string       t;
    @(posedge clk);
    #1;
    chk1("ack", bus.ack, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (bus.ack && e[16]) chk16(t, bus.dat_o, e[15:0]);
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    bus.cyc   = c;
    bus.stb   = s;
    bus.we    = w;
    bus.adr   = a;
    bus.dat_i = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step();
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] expv, input string tag);
    drive(1'b1, 1'b1, 1'b0, a, 16'h0);
    exp_q.push_back({1'b1, expv});
    tag_q.push_back(tag);
    step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, 1'b1, a, d);
    exp_q.push_back({1'b0, 16'h0});
    tag_q.push_back("wr");
    step();
  endtask

  task automatic wr_chk(input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] old, input string tag);
    drive(1'b1, 1'b1, 1'b1, a, d);
    exp_q.push_back({1'b1, old});
    tag_q.push_back(tag);
    step();
  endtask

  logic [15:0] exp_tab [8];

  initial begin
    // Reset with a write active: nothing acknowledged, nothing written.
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 16'h0004, 16'hFFFF);
    step();
    step();
    chk16("rst_dat_o", bus.dat_o, 16'h0);
    chk1("rst_irq", irq, 1'b0);
    rst = 1'b1;
    idle();
    for (int i = 0; i < 8; i++) rd(16'(i), 16'h0, "rst_reg");

    // Periodic mode: LOAD=3, COUNT=3, PRESCALE=1 -> expiry every 8 clocks.
    wr(16'h3, 16'h3);
    wr(16'h4, 16'h3);
    wr(16'h2, 16'h1);
    wr(16'h0, 16'h3);
    for (int k = 1; k <= 9; k++) rd(16'h1, (k >= 9) ? 16'h1 : 16'h0, "per_exp1");
    wr(16'h1, 16'h1);
    for (int k = 11; k <= 17; k++) rd(16'h1, (k == 17) ? 16'h1 : 16'h0, "per_exp2");
    for (int k = 18; k <= 25; k++) rd(16'h4, 16'((3 - ((k - 1) / 2)) & 3), "per_count");
    wr(16'h0, 16'h0);

    // One-shot: RELOAD=0, COUNT=2, PRESCALE=0.
    wr(16'h1, 16'h1);
    wr(16'h2, 16'h0);
    wr(16'h4, 16'h2);
    wr(16'h0, 16'h1);
    for (int k = 1; k <= 4; k++) rd(16'h1, (k == 4) ? 16'h1 : 16'h0, "os_exp");
    rd(16'h0, 16'h0, "os_ctrl");
    rd(16'h4, 16'h0, "os_count");
    idle();
    idle();
    rd(16'h4, 16'h0, "os_count_hold");

    // Back-to-back reads over the whole map, high address bits set.
    wr(16'h0, 16'h4);
    wr(16'h2, 16'h1234);
    wr(16'h3, 16'hBEEF);
    wr(16'h4, 16'hA5A5);
    exp_tab = '{16'h4, 16'h1, 16'h1234, 16'hBEEF, 16'hA5A5, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 8; i++) rd(16'hFFF8 | 16'(i), exp_tab[i], "map_rd");
    chk1("map_irq", irq, 1'b1);
    wr_chk(16'h5, 16'hFFFF, 16'h0, "wr5_old");
    rd(16'h5, 16'h0, "rd5");
    wr_chk(16'h4, 16'h0001, 16'hA5A5, "count_old");

    // Expiry coincident with a STATUS clear keeps EXP and irq.
    wr(16'h1, 16'h1);
    wr(16'h2, 16'h0);
    wr(16'h3, 16'h2);
    wr(16'h4, 16'h0);
    wr(16'h0, 16'h7);
    wr(16'h1, 16'h1);
    chk1("irq_g1", irq, 1'b0);
    rd(16'h1, 16'h1, "exp_kept");
    chk1("irq_g2", irq, 1'b1);
    wr(16'h0, 16'h4);
    chk1("irq_g3", irq, 1'b1);
    wr(16'h1, 16'h1);
    chk1("irq_g4", irq, 1'b1);
    idle();
    chk1("irq_clr", irq, 1'b0);

    // COUNT write wins over a tick; a CTRL write dropping EN swallows the tick.
    wr(16'h3, 16'h5);
    wr(16'h4, 16'h5);
    wr(16'h0, 16'h3);
    wr_chk(16'h4, 16'h00FF, 16'h5, "cw_old");
    rd(16'h4, 16'h00FF, "cw_val");
    rd(16'h4, 16'h00FE, "cw_dec");
    wr_chk(16'h0, 16'h2, 16'h3, "ctrl_old");
    rd(16'h4, 16'h00FD, "en_off_tick");
    rd(16'h4, 16'h00FD, "en_off_hold");

    // One-cycle reset mid-count with an access in flight.
    wr(16'h4, 16'h0);
    wr(16'h0, 16'h7);
    idle();
    idle();
    chk1("pre_rst_irq", irq, 1'b1);
    rd(16'h4, 16'h4, "pre_rst_count");
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'h4, 16'h0);
    step();
    chk16("mid_rst_dat_o", bus.dat_o, 16'h0);
    chk1("mid_rst_irq", irq, 1'b0);
    rst = 1'b1;
    idle();
    for (int i = 0; i < 5; i++) rd(16'(i), 16'h0, "post_rst_reg");
    chk1("post_rst_irq", irq, 1'b0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
